bcd_score_counter: RTL and testbench
====================================

# bcd_score_counter

Parametrised multi-digit BCD score register driven by the keypad decoder's one-hot key lines; its digit bus feeds the seven-segment display driver directly. Each new key press adds (or subtracts) one unit at the selected decimal weight, with carry/borrow rippling into higher digits. Overflow and underflow are selectable as saturate or wrap. Replaces the per-digit free-running counters: one update per press, with correct decimal carry.

## Interface
- `DIGITS`, default 4: number of BCD digits, 1..8; the key count equals `DIGITS`.
- `SATURATE`, default 1: 1 clamps at the all-9s and all-0s bounds; 0 wraps modulo 10^DIGITS.
- `clk` input, 1 bit: system clock; all state changes on its rising edge.
- `RST_BTN` input, 1 bit: reset, asynchronous assert, active-low.
- `btn` input, DIGITS bits: key levels from the keypad decoder, already synchronous to `clk`. Bit i selects weight 10^i.
- `dec` input, 1 bit: level; 1 makes accepted presses subtract instead of add.
- `clr` input, 1 bit: synchronous clear of score and flags.
- `digits` output, 4*DIGITS bits: BCD score; digit i occupies bits [4i+3:4i], and digit 0 is the ones digit.
- `ovf` output, 1 bit: sticky flag, set when an add exceeded the all-9s value.
- `unf` output, 1 bit: sticky flag, set when a subtract went below zero.
- `upd` output, 1 bit: one-cycle pulse, high for the cycle after an accepted press.

## Operation
- Edge detect: `btn_q` registers `btn` every cycle. `rise = btn & ~btn_q`.
- Holding a key produces exactly one update. Releasing a key produces no update.
- Selection: if `rise` has more than one bit set, the lowest-index set bit is accepted. The other rising bits in that cycle are discarded and do not retrigger while held.
- Priority per cycle: `clr` first, then an accepted press, otherwise hold.
- `clr`:
  - `digits`, `ovf`, `unf` and `upd` go to 0.
  - `btn_q` still updates, so a key held during `clr` is not counted afterwards.
- Add at weight i:
  - Digits below i are unchanged. Digit i is incremented.
  - A digit at 9 becomes 0 and carries into digit i+1, continuing up the chain.
  - Carry out of digit DIGITS-1 is overflow:
    - `SATURATE`=1: all digits become 9.
    - `SATURATE`=0: keep the wrapped result.
    - Either mode: set `ovf`.
- Subtract at weight i:
  - Digit i is decremented. A digit at 0 becomes 9 and borrows from digit i+1.
  - Borrow out of the top digit is underflow:
    - `SATURATE`=1: all digits become 0.
    - `SATURATE`=0: keep the wrapped result.
    - Either mode: set `unf`.
- Flags clear only on `clr` or reset.
- Digits never hold a value outside 0..9.
- `dec` is sampled in the same cycle as the accepted rise. Changing it while a key is held has no effect.

## Timing
- Reset (RST_BTN=0, asynchronous): `digits`=0, `btn_q`=0, `ovf`=0, `unf`=0, `upd`=0.
  - A key held through reset release counts as one press on the first edge.
- Latency: at the edge where `btn[i]`=1 and `btn_q[i]`=0, the new score is registered. It is visible on `digits` at that edge, together with `upd`=1 and any flag change.
- Throughput: one accepted press per cycle. Presses on different keys in consecutive cycles are all counted.
- Carry/borrow ripple resolves combinationally within one cycle; there is no multi-cycle busy state.
- `clr` and a rising key in the same cycle: clear wins, and that press is lost.

## Structure
- Package `score_pkg` holds:
  - `BCD_W`=4 and the digit constants `BCD_MAX`=9, `BCD_MIN`=0.
  - The `bcd_digit_t` typedef.
- Sub-module `bcd_digit`:
  - Inputs: current digit, `en`, `dec`, `cin`.
  - Outputs: next digit and `cout` (carry or borrow).
  - Instantiate it DIGITS times in a generate chain.
  - The top-level `en` one-hot comes from the priority select. A digit's `cin` is the `cout` of the digit below it.
- Top level holds the edge detect, the priority select, saturation override, and the flag/`upd` registers.

## Test plan
- Reset, then pulse `btn[0]` for one cycle ×12 → `digits`=0x0012, `upd` pulsed 12 times, flags 0.
- Hold `btn[1]` for 50 cycles from 0x0095 → `digits`=0x0105 after exactly one edge. No further change while held or on release.
- `btn`=4'b0110 rising together from 0 → `digits`=0x0010 (weight 10 only). Keep bit 2 held → no later update. Release and press it again → 0x0110.
- SATURATE=1, 0x9990, press `btn[1]` → 0x9999 with `ovf`=1. SATURATE=0, same stimulus → 0x0000 with `ovf`=1.
- `dec`=1 from 0x0100, press `btn[0]` → 0x0099. From 0x0000, press `btn[3]` → SATURATE=1 gives 0x0000 with `unf`=1. SATURATE=0 gives 0x9000 with `unf`=1.
- Assert RST_BTN low mid-sequence, asynchronously between edges → `digits`, flags and `upd` go to 0 immediately. `clr` in the same cycle as a rise → 0x0000 and no `upd`.

Source files
------------

// File: rtl/score_pkg.sv
// Shared BCD digit type and digit bound constants for the score counter.
package score_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_score_counter_if.sv
// Keypad-side bus of the score counter: key lines and controls in,
// BCD score, sticky flags and update pulse out.
interface bcd_score_counter_if #(
    parameter int unsigned DIGITS = 4
);
    logic [DIGITS-1:0]   btn;
    logic                dec;
    logic                clr;
    logic [4*DIGITS-1:0] digits;
    logic                ovf;
    logic                unf;
    logic                upd;

    modport master (
        output btn, dec, clr,
        input  digits, ovf, unf, upd
    );

    modport slave (
        input  btn, dec, clr,
        output digits, ovf, unf, upd
    );
endinterface

// File: rtl/bcd_digit.sv
// One decade of the score chain: steps the digit up or down by one when
// selected directly or when the digit below carries/borrows into it.
module bcd_digit
    import score_pkg::*;
(
    input  bcd_digit_t d_i,
    input  logic       en_i,
    input  logic       dec_i,
    input  logic       cin_i,
    output bcd_digit_t d_o,
    output logic       cout_o
);

    // Next digit value and carry/borrow out of this decade.
    always_comb begin
        d_o    = d_i;
        cout_o = 1'b0;
        if (en_i || cin_i) begin
            if (dec_i) begin
                if (d_i == BCD_MIN) begin
                    d_o    = BCD_MAX;
                    cout_o = 1'b1;
                end else begin
                    d_o = d_i - 4'd1;
                end
            end else begin
                if (d_i >= BCD_MAX) begin
                    d_o    = BCD_MIN;
                    cout_o = 1'b1;
                end else begin
                    d_o = d_i + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score register: one add/subtract per key press at the
// key's decimal weight, with rippling carry/borrow and saturate or wrap.
module bcd_score_counter
    import score_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                      clk,
    input  logic                      RST_BTN,
    bcd_score_counter_if.slave        bus
);

    localparam int unsigned           W         = BCD_W * DIGITS;
    localparam logic [W-1:0]          ALL_NINES = {DIGITS{BCD_MAX}};

    logic [DIGITS-1:0] btn_q;
    logic [DIGITS-1:0] rise;
    logic [DIGITS-1:0] sel;
    logic [W-1:0]      digits_q;
    logic [W-1:0]      digits_d;
    logic [W-1:0]      chain_d;
    logic [DIGITS:0]   carry;
    logic              ovf_q;
    logic              unf_q;
    logic              upd_q;

    assign rise = bus.btn & ~btn_q;
    // Isolate the lowest set bit: other simultaneous rises are dropped and,
    // since btn_q still samples them, never retrigger while held.
    assign sel  = rise & (~rise + DIGITS'(1));

    assign carry[0] = 1'b0;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .d_i    (digits_q[g*BCD_W +: BCD_W]),
            .en_i   (sel[g]),
            .dec_i  (bus.dec),
            .cin_i  (carry[g]),
            .d_o    (chain_d[g*BCD_W +: BCD_W]),
            .cout_o (carry[g+1])
        );
    end

    // Clamp to the bound on carry/borrow out of the top digit in saturate mode.
    always_comb begin
        digits_d = chain_d;
        if (SATURATE && carry[DIGITS]) begin
            digits_d = bus.dec ? '0 : ALL_NINES;
        end
    end

    // Edge-detect register, score, sticky flags and update pulse.
    always_ff @(posedge clk or negedge RST_BTN) begin
        if (!RST_BTN) begin
            btn_q    <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            btn_q <= bus.btn;
            if (bus.clr) begin
                digits_q <= '0;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
                upd_q    <= 1'b0;
            end else if (|sel) begin
                digits_q <= digits_d;
                upd_q    <= 1'b1;
                if (carry[DIGITS] && !bus.dec) ovf_q <= 1'b1;
                if (carry[DIGITS] &&  bus.dec) unf_q <= 1'b1;
            end else begin
                upd_q <= 1'b0;
            end
        end
    end

    assign bus.digits = digits_q;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
    assign bus.upd    = upd_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench for bcd_score_counter: a saturating and a wrapping
// instance receive identical keypad stimulus.
module tb_bcd_score_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       dec;
    logic       clr;
    int         tests = 0;
    int         failed = 0;
    int         upd_cnt = 0;

    bcd_score_counter_if #(.DIGITS(4)) if_s ();
    bcd_score_counter_if #(.DIGITS(4)) if_w ();

    assign if_s.btn = btn;
    assign if_s.dec = dec;
    assign if_s.clr = clr;
    assign if_w.btn = btn;
    assign if_w.dec = dec;
    assign if_w.clr = clr;

    bcd_score_counter #(.DIGITS(4), .SATURATE(1'b1)) u_sat (
        .clk     (clk),
        .RST_BTN (rst_n),
        .bus     (if_s)
    );

    bcd_score_counter #(.DIGITS(4), .SATURATE(1'b0)) u_wrap (
        .clk     (clk),
        .RST_BTN (rst_n),
        .bus     (if_w)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int unsigned idx);
        btn[idx] = 1'b1;
        step();
        if (if_s.upd === 1'b1) upd_cnt++;
        btn = '0;
        step();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = '0; dec = 1'b0; clr = 1'b0;
        step(); step();
        tests++; if (if_s.digits !== 16'h0000 || if_s.upd !== 1'b0) begin failed++; $display("FAIL reset_sat digits=%h upd=%b exp 0000/0", if_s.digits, if_s.upd); end
        tests++; if (if_s.ovf !== 1'b0 || if_s.unf !== 1'b0) begin failed++; $display("FAIL reset_flags ovf=%b unf=%b exp 0/0", if_s.ovf, if_s.unf); end
        tests++; if (if_w.digits !== 16'h0000 || if_w.upd !== 1'b0) begin failed++; $display("FAIL reset_wrap digits=%h upd=%b exp 0000/0", if_w.digits, if_w.upd); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_presses();
        upd_cnt = 0;
        for (int i = 0; i < 12; i++) press(0);
        tests++; if (if_s.digits !== 16'h0012) begin failed++; $display("FAIL ones_x12 got=%h exp=0012", if_s.digits); end
        tests++; if (upd_cnt !== 12) begin failed++; $display("FAIL ones_upd_count got=%0d exp=12", upd_cnt); end
        tests++; if (if_s.ovf !== 1'b0 || if_s.unf !== 1'b0 || if_w.digits !== 16'h0012) begin failed++; $display("FAIL ones_flags ovf=%b unf=%b wrap=%h exp 0/0/0012", if_s.ovf, if_s.unf, if_w.digits); end
    endtask

    task automatic test_hold();
        int bad = 0;
        for (int i = 0; i < 8; i++) press(1);
        for (int i = 0; i < 3; i++) press(0);
        tests++; if (if_s.digits !== 16'h0095) begin failed++; $display("FAIL hold_preload got=%h exp=0095", if_s.digits); end
        btn = 4'b0010;
        step();
        tests++; if (if_s.digits !== 16'h0105 || if_s.upd !== 1'b1) begin failed++; $display("FAIL hold_first_edge digits=%h upd=%b exp 0105/1", if_s.digits, if_s.upd); end
        for (int i = 0; i < 49; i++) begin
            step();
            if (if_s.digits !== 16'h0105 || if_s.upd !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin failed++; $display("FAIL hold_no_repeat bad_cycles=%0d exp=0", bad); end
        btn = '0;
        step();
        tests++; if (if_s.digits !== 16'h0105 || if_s.upd !== 1'b0) begin failed++; $display("FAIL hold_release digits=%h upd=%b exp 0105/0", if_s.digits, if_s.upd); end
    endtask

    task automatic test_multi_rise();
        do_clr();
        tests++; if (if_s.digits !== 16'h0000) begin failed++; $display("FAIL clr_score got=%h exp=0000", if_s.digits); end
        btn = 4'b0110;
        step();
        tests++; if (if_s.digits !== 16'h0010 || if_s.upd !== 1'b1) begin failed++; $display("FAIL multi_lowest digits=%h upd=%b exp 0010/1", if_s.digits, if_s.upd); end
        btn = 4'b0100;
        step();
        tests++; if (if_s.digits !== 16'h0010 || if_s.upd !== 1'b0) begin failed++; $display("FAIL multi_discarded digits=%h upd=%b exp 0010/0", if_s.digits, if_s.upd); end
        btn = '0;
        step();
        press(2);
        tests++; if (if_s.digits !== 16'h0110) begin failed++; $display("FAIL multi_repress got=%h exp=0110", if_s.digits); end
    endtask

    task automatic test_clr_with_rise();
        clr = 1'b1; btn = 4'b0001;
        step();
        tests++; if (if_s.digits !== 16'h0000 || if_s.upd !== 1'b0) begin failed++; $display("FAIL clr_rise digits=%h upd=%b exp 0000/0", if_s.digits, if_s.upd); end
        clr = 1'b0;
        step();
        tests++; if (if_s.digits !== 16'h0000 || if_s.upd !== 1'b0) begin failed++; $display("FAIL clr_held_after digits=%h upd=%b exp 0000/0", if_s.digits, if_s.upd); end
        btn = '0;
        step();
    endtask

    task automatic test_overflow();
        do_clr();
        for (int i = 0; i < 9; i++) press(3);
        for (int i = 0; i < 9; i++) press(2);
        for (int i = 0; i < 9; i++) press(1);
        tests++; if (if_s.digits !== 16'h9990 || if_w.digits !== 16'h9990) begin failed++; $display("FAIL ovf_preload sat=%h wrap=%h exp 9990", if_s.digits, if_w.digits); end
        press(1);
        tests++; if (if_s.digits !== 16'h9999 || if_s.ovf !== 1'b1) begin failed++; $display("FAIL ovf_sat digits=%h ovf=%b exp 9999/1", if_s.digits, if_s.ovf); end
        tests++; if (if_w.digits !== 16'h0000 || if_w.ovf !== 1'b1) begin failed++; $display("FAIL ovf_wrap digits=%h ovf=%b exp 0000/1", if_w.digits, if_w.ovf); end
        tests++; if (if_s.unf !== 1'b0 || if_w.unf !== 1'b0) begin failed++; $display("FAIL ovf_no_unf sat=%b wrap=%b exp 0", if_s.unf, if_w.unf); end
        press(0);
        tests++; if (if_s.digits !== 16'h9999 || if_w.digits !== 16'h0001 || if_w.ovf !== 1'b1) begin failed++; $display("FAIL ovf_sticky sat=%h wrap=%h wovf=%b exp 9999/0001/1", if_s.digits, if_w.digits, if_w.ovf); end
    endtask

    task automatic test_decrement();
        do_clr();
        tests++; if (if_w.ovf !== 1'b0 || if_s.ovf !== 1'b0) begin failed++; $display("FAIL clr_flags sat=%b wrap=%b exp 0", if_s.ovf, if_w.ovf); end
        press(2);
        dec = 1'b1;
        press(0);
        tests++; if (if_s.digits !== 16'h0099 || if_s.unf !== 1'b0) begin failed++; $display("FAIL dec_borrow digits=%h unf=%b exp 0099/0", if_s.digits, if_s.unf); end
        do_clr();
        press(3);
        tests++; if (if_s.digits !== 16'h0000 || if_s.unf !== 1'b1) begin failed++; $display("FAIL unf_sat digits=%h unf=%b exp 0000/1", if_s.digits, if_s.unf); end
        tests++; if (if_w.digits !== 16'h9000 || if_w.unf !== 1'b1) begin failed++; $display("FAIL unf_wrap digits=%h unf=%b exp 9000/1", if_w.digits, if_w.unf); end
        dec = 1'b0; btn = 4'b0010;
        step();
        dec = 1'b1;
        step();
        tests++; if (if_s.digits !== 16'h0010 || if_w.digits !== 16'h9010 || if_s.upd !== 1'b0) begin failed++; $display("FAIL dec_while_held sat=%h wrap=%h upd=%b exp 0010/9010/0", if_s.digits, if_w.digits, if_s.upd); end
        btn = '0; dec = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        btn = 4'b0001;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if (if_s.digits !== 16'h0000 || if_s.upd !== 1'b0 || if_s.unf !== 1'b0) begin failed++; $display("FAIL async_rst_sat digits=%h upd=%b unf=%b exp 0000/0/0", if_s.digits, if_s.upd, if_s.unf); end
        tests++; if (if_w.digits !== 16'h0000 || if_w.unf !== 1'b0) begin failed++; $display("FAIL async_rst_wrap digits=%h unf=%b exp 0000/0", if_w.digits, if_w.unf); end
        #2;
        rst_n = 1'b1;
        step();
        tests++; if (if_s.digits !== 16'h0001 || if_s.upd !== 1'b1) begin failed++; $display("FAIL held_through_reset digits=%h upd=%b exp 0001/1", if_s.digits, if_s.upd); end
        btn = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_presses();
        test_hold();
        test_multi_rise();
        test_clr_with_rise();
        test_overflow();
        test_decrement();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
